sa_act_skew_feeder: RTL and testbench
=====================================

# sa_act_skew_feeder

Activation feeder that sits directly upstream of the systolic array's west edge and drives the `a_in` port of each PE row. It buffers a burst of activation vectors, one element per array row, then replays them with a diagonal skew: row r is delayed r cycles. The skew is what a weight-stationary array of `pe` cells needs so that partial sums meet the correct activations. Idle row slots are driven with zero, so the MAC contribution is nil.

## Interface

Parameters:
- `DATA_W`, 8, activation element width (matches `pe` `DATA_W`)
- `ROWS`, 4, number of array rows fed
- `DEPTH`, 8, maximum vectors per burst (FIFO entries)

Ports:
- `clk`, in, 1, single clock; all state updates on its rising edge
- `rst`, in, 1, reset, synchronous, active-high
- `clear`, in, 1, synchronous abort: empties the FIFO and returns to IDLE (same effect as `rst`)
- `in_valid`, in, 1, upstream vector valid
- `in_ready`, out, 1, feeder can accept a vector
- `in_vec`, in, ROWS*DATA_W, vector; row r element at `[r*DATA_W +: DATA_W]`
- `in_last`, in, 1, marks the final vector of a burst
- `a_out`, out, ROWS*DATA_W, per-row activation to the PE `a_in`, same packing as `in_vec`
- `a_valid`, out, ROWS, bit r is high when row r of `a_out` carries real data
- `busy`, out, 1, high in STREAM and FLUSH
- `done`, out, 1, one-cycle pulse when the last skewed element has left
- `burst_len`, out, $clog2(DEPTH+1), number of vectors N in the current or last burst

## Operation

- FSM states: IDLE, STREAM, FLUSH, DONE.
- **IDLE**
  - `in_ready` = (count < DEPTH).
  - A beat is accepted when `in_valid && in_ready` and is written to the FIFO; count increments.
  - Go to STREAM when a beat is accepted with `in_last`, or when the DEPTH-th beat is accepted (auto-close, `in_last` ignored).
- **STREAM**
  - Pops one vector per cycle into the skew network. Row r passes through r register stages; row 0 has no extra stage beyond the output register.
  - Go to FLUSH after the Nth pop.
  - `in_ready` = 0; `in_valid` is ignored.
- **FLUSH**
  - Injects zero/invalid for ROWS-1 cycles to drain the skew network.
  - Then go to DONE.
- **DONE**
  - `done` = 1 for one cycle.
  - Then IDLE; count resets to 0; `burst_len` holds N.
- **Output rule:** when `a_valid[r]` = 0, `a_out` row r = 0 exactly. There are no stale values.
- **Width rules:**
  - Elements pass through unmodified; no arithmetic.
  - `burst_len` counts 1..DEPTH.
- **`clear` / `rst`:**
  - Take effect at the next edge from any state.
  - FIFO count = 0, skew registers = 0, state = IDLE.
  - No `done` pulse; `burst_len` = 0.
  - A beat presented in the same cycle as `clear` is dropped.
- `rst` takes priority over `clear`; both take priority over any handshake.

## Timing

- **Reset values:** `a_out` = 0, `a_valid` = 0, `busy` = 0, `done` = 0, `burst_len` = 0. `in_ready` is forced 0 while `rst` or `clear` is high, and is 1 the cycle after they drop.
- **Cycle numbering:** let t = 0 be the first cycle after the closing beat is accepted (first STREAM cycle).
- **Skew schedule:** row r presents element r of vector k (k = 0..N-1) during cycle t = 1 + k + r, with `a_valid[r]` = 1 in that cycle only.
- **Cycle counts:**
  - `busy` = 1 for t = 0 .. N+ROWS-2.
  - Last valid output (row ROWS-1, vector N-1) is at t = N+ROWS-1.
  - `done` = 1 at t = N+ROWS-1+1 = N+ROWS.
  - `in_ready` = 1 again from t = N+ROWS+1.
- **Upstream gaps:** bubbles in `in_valid` during IDLE do not affect the output schedule. Streaming starts only after the burst closes.
- **Inter-beat timing:** back-to-back beats are accepted every cycle (`in_ready` stays 1 until count = DEPTH).

## Test plan

- **Reset:** hold `rst` 2 cycles mid-burst.
  - Required: all outputs 0; `in_ready` = 1 the cycle after release; no `done`.
- **Single vector:** N=1, ROWS=4, `in_vec` = {4,3,2,1} with `in_last`.
  - Required: row0=1 at t=1, row1=2 at t=2, row2=3 at t=3, row3=4 at t=4; `done` at t=5; all other slots 0 with `a_valid` 0.
- **Three vectors** {1..4}, {5..8}, {9..12} with 1-cycle `in_valid` gaps.
  - Required: at t=3, `a_out` = {row0=9, row1=6, row2=3, row3=x with `a_valid[3]`=0, value 0}; `done` at t=7; `burst_len` = 3.
- **Auto-close:** DEPTH=8 beats without `in_last`.
  - Required: `in_ready` drops after the 8th beat; STREAM starts; `done` at t=12; the 9th `in_valid` is ignored until IDLE.
- **Abort:** `clear` pulsed at t=3 of a 3-vector burst.
  - Required: next cycle `a_out` = 0, `a_valid` = 0, `busy` = 0, no `done`; a fresh 1-vector burst then behaves as in the single-vector scenario.
- **Beat during `clear`:** `in_valid`+`in_last` in the same cycle as `clear`.
  - Required: beat dropped; state IDLE; count 0.

Source files
------------

// File: rtl/sa_act_skew_feeder_if.sv
// Bus between the activation source and the skew feeder: upstream vector
// handshake, abort, and the skewed west-edge outputs toward the PE rows.
interface sa_act_skew_feeder_if #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int DEPTH  = 8
);
    logic                         clear;
    logic                         in_valid;
    logic                         in_ready;
    logic [ROWS*DATA_W-1:0]       in_vec;
    logic                         in_last;
    logic [ROWS*DATA_W-1:0]       a_out;
    logic [ROWS-1:0]              a_valid;
    logic                         busy;
    logic                         done;
    logic [$clog2(DEPTH+1)-1:0]   burst_len;

    modport master (
        output clear, in_valid, in_vec, in_last,
        input  in_ready, a_out, a_valid, busy, done, burst_len
    );

    modport slave (
        input  clear, in_valid, in_vec, in_last,
        output in_ready, a_out, a_valid, busy, done, burst_len
    );
endinterface

// File: rtl/sa_act_skew_feeder.sv
// Burst-buffering activation feeder: collects up to DEPTH vectors, then replays
// them with row r delayed r cycles so a weight-stationary array sees a diagonal wavefront.

module sa_skew_lane #(
    parameter int DATA_W = 8,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] d_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] d_o
);
    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1][DATA_W-1:0] data_pipe;

    // Data is zeroed on entry when invalid, so every stage is zero whenever its valid is low.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe[1]  <= vld_i;
            data_pipe[1] <= vld_i ? d_i : '0;
            for (int j = 2; j <= STAGES; j++) begin
                vld_pipe[j]  <= vld_pipe[j-1];
                data_pipe[j] <= data_pipe[j-1];
            end
        end
    end

    assign vld_o = vld_pipe[STAGES];
    assign d_o   = data_pipe[STAGES];
endmodule

module sa_act_skew_feeder #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sa_act_skew_feeder_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_e;

    state_e                         state_q, state_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [CW-1:0]                  rd_q, rd_d;
    logic [CW-1:0]                  blen_q, blen_d;
    logic [FW-1:0]                  fl_q, fl_d;
    logic                           done_q, done_d;
    logic [DEPTH-1:0][ROWS*DATA_W-1:0] mem_q;
    logic                           accept;
    logic                           pop;
    logic                           last_pop;
    logic                           abort;

    assign abort = bus.clear;

    // done_q marks the pulse cycle; the FSM is already IDLE then but not yet accepting.
    assign bus.in_ready = !rst && !bus.clear && (state_q == S_IDLE) && !done_q
                          && (count_q < CW'(DEPTH));
    assign accept   = bus.in_valid && bus.in_ready;
    assign pop      = (state_q == S_STREAM);
    assign last_pop = pop && (rd_q == count_q - CW'(1));

    always_ff @(posedge clk) begin
        if (accept) mem_q[count_q[AW-1:0]] <= bus.in_vec;
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rd_q    <= '0;
            blen_q  <= '0;
            fl_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            blen_q  <= blen_d;
            fl_q    <= fl_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rd_d    = rd_q;
        fl_d    = fl_q;
        blen_d  = blen_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    count_d = count_q + CW'(1);
                    // A full FIFO closes the burst regardless of in_last.
                    if (bus.in_last || (count_q == CW'(DEPTH - 1))) begin
                        state_d = S_STREAM;
                        blen_d  = count_q + CW'(1);
                        rd_d    = '0;
                    end
                end
            end
            S_STREAM: begin
                rd_d = rd_q + CW'(1);
                if (last_pop) begin
                    rd_d    = '0;
                    fl_d    = '0;
                    state_d = (ROWS > 1) ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: begin
                fl_d = fl_q + FW'(1);
                if (fl_q == FW'(ROWS - 2)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                count_d = '0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        sa_skew_lane #(.DATA_W(DATA_W), .STAGES(r + 1)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .flush_i (abort),
            .vld_i   (pop),
            .d_i     (mem_q[rd_q[AW-1:0]][r*DATA_W +: DATA_W]),
            .vld_o   (bus.a_valid[r]),
            .d_o     (bus.a_out[r*DATA_W +: DATA_W])
        );
    end

    assign bus.busy      = (state_q == S_STREAM) || (state_q == S_FLUSH);
    assign bus.done      = done_q;
    assign bus.burst_len = blen_q;
endmodule

// File: tb/tb_sa_act_skew_feeder.sv
// Directed bench for the activation skew feeder: hand-built bursts checked
// cycle by cycle against the diagonal schedule and handshake timing.
module tb_sa_act_skew_feeder;
    localparam int DATA_W = 8;
    localparam int ROWS   = 4;
    localparam int DEPTH  = 8;
    localparam int LW     = $clog2(DEPTH + 1);
    localparam int VW     = ROWS * DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sa_act_skew_feeder_if #(.DATA_W(DATA_W), .ROWS(ROWS), .DEPTH(DEPTH)) bus ();

    sa_act_skew_feeder #(.DATA_W(DATA_W), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [VW-1:0]   vq [DEPTH];
    logic [VW-1:0]   cap_a    [32];
    logic [ROWS-1:0] cap_v    [32];
    logic            cap_busy [32];
    logic            cap_done [32];
    logic            cap_rdy  [32];
    logic [LW-1:0]   cap_bl   [32];

    function automatic logic [VW-1:0] exp_a(input int n, input int t);
        logic [VW-1:0] res = '0;
        for (int r = 0; r < ROWS; r++) begin
            int k = t - 1 - r;
            if (k >= 0 && k < n) res[r*DATA_W +: DATA_W] = vq[k][r*DATA_W +: DATA_W];
        end
        return res;
    endfunction

    function automatic logic [ROWS-1:0] exp_v(input int n, input int t);
        logic [ROWS-1:0] res = '0;
        for (int r = 0; r < ROWS; r++) begin
            int k = t - 1 - r;
            if (k >= 0 && k < n) res[r] = 1'b1;
        end
        return res;
    endfunction

    task automatic idle_inputs();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_vec   = '0;
    endtask

    // Called at posedge+1; presents one beat for one edge.
    task automatic send(input logic [VW-1:0] v, input logic last);
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        bus.in_last  = last;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    // Records outputs for cycles t = 0 .. n-1, starting at posedge+1 of t = 0.
    task automatic capture(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            cap_a[t]    = bus.a_out;
            cap_v[t]    = bus.a_valid;
            cap_busy[t] = bus.busy;
            cap_done[t] = bus.done;
            cap_rdy[t]  = bus.in_ready;
            cap_bl[t]   = bus.burst_len;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.a_out, bus.a_valid, bus.busy, bus.done, bus.burst_len} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got a=%h v=%b busy=%b done=%b bl=%0d want all zero",
                     bus.a_out, bus.a_valid, bus.busy, bus.done, bus.burst_len);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.in_ready); end
        @(posedge clk); #1;
        vq[0] = 32'h04030201; vq[1] = 32'h08070605; vq[2] = 32'h0C0B0A09;
        send(vq[0], 1'b0); send(vq[1], 1'b0); send(vq[2], 1'b1);
        capture(2);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_forced got=%b want=0", bus.in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus.a_out, bus.a_valid, bus.busy, bus.done, bus.burst_len} !== '0) begin
            failures++;
            $display("FAIL reset_mid_burst got a=%h v=%b busy=%b done=%b bl=%0d want all zero",
                     bus.a_out, bus.a_valid, bus.busy, bus.done, bus.burst_len);
        end
        @(posedge clk); #1 rst = 1'b0;
        capture(8);
        checks++;
        if (cap_rdy[0] !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b want=1", cap_rdy[0]); end
        for (int t = 0; t < 8; t++) begin
            checks++;
            if (cap_done[t] !== 1'b0 || cap_v[t] !== '0 || cap_busy[t] !== 1'b0) begin
                failures++;
                $display("FAIL reset_quiet t=%0d done=%b v=%b busy=%b want 0", t, cap_done[t], cap_v[t], cap_busy[t]);
            end
        end
    endtask

    task automatic test_single();
        vq[0] = 32'h04030201;
        send(vq[0], 1'b1);
        capture(8);
        for (int t = 0; t < 8; t++) begin
            checks += 5;
            if (cap_a[t] !== exp_a(1, t)) begin failures++; $display("FAIL single_a_out t=%0d got=%h want=%h", t, cap_a[t], exp_a(1, t)); end
            if (cap_v[t] !== exp_v(1, t)) begin failures++; $display("FAIL single_a_valid t=%0d got=%b want=%b", t, cap_v[t], exp_v(1, t)); end
            if (cap_done[t] !== (t == 5)) begin failures++; $display("FAIL single_done t=%0d got=%b", t, cap_done[t]); end
            if (cap_busy[t] !== (t <= 3)) begin failures++; $display("FAIL single_busy t=%0d got=%b", t, cap_busy[t]); end
            if (cap_rdy[t] !== (t >= 6)) begin failures++; $display("FAIL single_ready t=%0d got=%b", t, cap_rdy[t]); end
        end
        checks += 3;
        if (cap_a[1] !== 32'h00000001) begin failures++; $display("FAIL single_row0_t1 got=%h want=00000001", cap_a[1]); end
        if (cap_a[4] !== 32'h04000000) begin failures++; $display("FAIL single_row3_t4 got=%h want=04000000", cap_a[4]); end
        if (cap_bl[6] !== LW'(1)) begin failures++; $display("FAIL single_burst_len got=%0d want=1", cap_bl[6]); end
    endtask

    task automatic test_three_gaps();
        vq[0] = 32'h04030201; vq[1] = 32'h08070605; vq[2] = 32'h0C0B0A09;
        send(vq[0], 1'b0); gap();
        send(vq[1], 1'b0); gap();
        send(vq[2], 1'b1);
        capture(10);
        for (int t = 0; t < 10; t++) begin
            checks += 4;
            if (cap_a[t] !== exp_a(3, t)) begin failures++; $display("FAIL three_a_out t=%0d got=%h want=%h", t, cap_a[t], exp_a(3, t)); end
            if (cap_v[t] !== exp_v(3, t)) begin failures++; $display("FAIL three_a_valid t=%0d got=%b want=%b", t, cap_v[t], exp_v(3, t)); end
            if (cap_done[t] !== (t == 7)) begin failures++; $display("FAIL three_done t=%0d got=%b", t, cap_done[t]); end
            if (cap_busy[t] !== (t <= 5)) begin failures++; $display("FAIL three_busy t=%0d got=%b", t, cap_busy[t]); end
        end
        checks += 3;
        if (cap_a[3] !== 32'h00030609) begin failures++; $display("FAIL three_t3_a_out got=%h want=00030609", cap_a[3]); end
        if (cap_v[3] !== 4'b0111) begin failures++; $display("FAIL three_t3_a_valid got=%b want=0111", cap_v[3]); end
        if (cap_bl[8] !== LW'(3)) begin failures++; $display("FAIL three_burst_len got=%0d want=3", cap_bl[8]); end
    endtask

    task automatic test_autoclose();
        for (int k = 0; k < DEPTH; k++)
            vq[k] = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
        for (int k = 0; k < DEPTH; k++) begin
            bus.in_valid = 1'b1; bus.in_vec = vq[k]; bus.in_last = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL auto_fill_ready beat=%0d got=%b want=1", k, bus.in_ready); end
            @(posedge clk); #1;
        end
        // Ninth beat stays asserted; it must wait until the feeder is idle again.
        bus.in_vec = 32'hDEADBEEF; bus.in_last = 1'b1;
        capture(14);
        for (int t = 0; t < 14; t++) begin
            checks += 5;
            if (cap_a[t] !== exp_a(DEPTH, t)) begin failures++; $display("FAIL auto_a_out t=%0d got=%h want=%h", t, cap_a[t], exp_a(DEPTH, t)); end
            if (cap_v[t] !== exp_v(DEPTH, t)) begin failures++; $display("FAIL auto_a_valid t=%0d got=%b want=%b", t, cap_v[t], exp_v(DEPTH, t)); end
            if (cap_done[t] !== (t == 12)) begin failures++; $display("FAIL auto_done t=%0d got=%b", t, cap_done[t]); end
            if (cap_busy[t] !== (t <= 10)) begin failures++; $display("FAIL auto_busy t=%0d got=%b", t, cap_busy[t]); end
            if (cap_rdy[t] !== (t >= 13)) begin failures++; $display("FAIL auto_ready t=%0d got=%b", t, cap_rdy[t]); end
        end
        checks++;
        if (cap_bl[12] !== LW'(DEPTH)) begin failures++; $display("FAIL auto_burst_len got=%0d want=%0d", cap_bl[12], DEPTH); end
        idle_inputs();
        vq[0] = 32'hDEADBEEF;
        capture(7);
        checks += 3;
        if (cap_a[1] !== 32'h000000EF) begin failures++; $display("FAIL auto_ninth_row0 got=%h want=000000ef", cap_a[1]); end
        if (cap_a[4] !== 32'hDE000000) begin failures++; $display("FAIL auto_ninth_row3 got=%h want=de000000", cap_a[4]); end
        if (cap_done[5] !== 1'b1) begin failures++; $display("FAIL auto_ninth_done got=%b want=1", cap_done[5]); end
    endtask

    task automatic test_abort();
        vq[0] = 32'h04030201; vq[1] = 32'h08070605; vq[2] = 32'h0C0B0A09;
        send(vq[0], 1'b0); send(vq[1], 1'b0); send(vq[2], 1'b1);
        capture(3);
        bus.clear = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.a_valid !== 4'b0111) begin failures++; $display("FAIL abort_pre_valid got=%b want=0111", bus.a_valid); end
        @(posedge clk); #1 bus.clear = 1'b0;
        capture(8);
        checks += 2;
        if ({cap_a[0], cap_v[0], cap_busy[0], cap_done[0], cap_bl[0]} !== '0) begin
            failures++;
            $display("FAIL abort_outputs got a=%h v=%b busy=%b done=%b bl=%0d want all zero",
                     cap_a[0], cap_v[0], cap_busy[0], cap_done[0], cap_bl[0]);
        end
        if (cap_rdy[0] !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b want=1", cap_rdy[0]); end
        for (int t = 0; t < 8; t++) begin
            checks++;
            if (cap_done[t] !== 1'b0 || cap_v[t] !== '0) begin failures++; $display("FAIL abort_no_done t=%0d done=%b v=%b", t, cap_done[t], cap_v[t]); end
        end
        vq[0] = 32'h44332211;
        send(vq[0], 1'b1);
        capture(7);
        for (int t = 0; t < 7; t++) begin
            checks += 3;
            if (cap_a[t] !== exp_a(1, t)) begin failures++; $display("FAIL abort_fresh_a_out t=%0d got=%h want=%h", t, cap_a[t], exp_a(1, t)); end
            if (cap_v[t] !== exp_v(1, t)) begin failures++; $display("FAIL abort_fresh_a_valid t=%0d got=%b want=%b", t, cap_v[t], exp_v(1, t)); end
            if (cap_done[t] !== (t == 5)) begin failures++; $display("FAIL abort_fresh_done t=%0d got=%b", t, cap_done[t]); end
        end
    endtask

    task automatic test_beat_during_clear();
        bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.in_vec = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL clear_beat_ready got=%b want=0", bus.in_ready); end
        @(posedge clk); #1;
        idle_inputs();
        capture(6);
        for (int t = 0; t < 6; t++) begin
            checks++;
            if (cap_busy[t] !== 1'b0 || cap_v[t] !== '0 || cap_done[t] !== 1'b0 || cap_rdy[t] !== 1'b1) begin
                failures++;
                $display("FAIL clear_beat_dropped t=%0d busy=%b v=%b done=%b rdy=%b", t, cap_busy[t], cap_v[t], cap_done[t], cap_rdy[t]);
            end
        end
        vq[0] = 32'h0D0C0B0A;
        send(vq[0], 1'b1);
        capture(7);
        checks += 3;
        if (cap_a[2] !== 32'h00000B00) begin failures++; $display("FAIL clear_fresh_row1 got=%h want=00000b00", cap_a[2]); end
        if (cap_done[5] !== 1'b1) begin failures++; $display("FAIL clear_fresh_done got=%b want=1", cap_done[5]); end
        if (cap_bl[6] !== LW'(1)) begin failures++; $display("FAIL clear_fresh_burst_len got=%0d want=1", cap_bl[6]); end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_single();
        test_three_gaps();
        test_autoclose();
        test_abort();
        test_beat_during_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
